ace_aw_snoop_dispatcher: RTL and testbench

//  Sits directly downstream of the AW transaction decoder. Registers one write request plus its decoded

---
 rtl/ace_aw_snoop_dispatcher.sv | 162 ++++++++++++++++
 tb/tb_ace_aw_snoop_dispatcher.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ace_aw_snoop_dispatcher.sv
// AW snoop dispatcher: holds one write at a time. Snooping writes broadcast AC to all peer
// masters and gather CR before the AW goes downstream. Illegal writes are reported on the error port.
package ace_aw_snoop_pkg;
  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        prot;
  } aw_chan_t;

  typedef struct packed {
    logic [3:0] snoop_trs;
  } snoop_info_t;

  localparam logic [3:0] ACSNOOP_CLEAN_INVALID = 4'b1001;
  localparam logic [3:0] ACSNOOP_MAKE_INVALID  = 4'b1101;
endpackage

module ace_aw_snoop_dispatcher #(
  parameter int  NUM_SNP      = 2,
  parameter type aw_chan_t    = ace_aw_snoop_pkg::aw_chan_t,
  parameter type snoop_info_t = ace_aw_snoop_pkg::snoop_info_t,
  parameter int  ADDR_W       = ace_aw_snoop_pkg::ADDR_W,
  parameter int  ID_W         = ace_aw_snoop_pkg::ID_W,
  parameter int  IDX_W        = (NUM_SNP > 1) ? $clog2(NUM_SNP) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  aw_chan_t             aw_i,
  input  logic [IDX_W-1:0]     init_idx_i,
  input  logic                 snooping_i,
  input  snoop_info_t          snoop_info_i,
  input  logic                 illegal_trs_i,
  output logic [NUM_SNP-1:0]   ac_valid_o,
  input  logic [NUM_SNP-1:0]   ac_ready_i,
  output logic [ADDR_W-1:0]    ac_addr_o,
  output logic [2:0]           ac_prot_o,
  output logic [3:0]           ac_snoop_o,
  input  logic [NUM_SNP-1:0]   cr_valid_i,
  output logic [NUM_SNP-1:0]   cr_ready_o,
  input  logic [5*NUM_SNP-1:0] cr_resp_i,
  output logic                 aw_valid_o,
  input  logic                 aw_ready_i,
  output aw_chan_t             aw_o,
  output logic [4:0]           cr_resp_o,
  output logic                 err_valid_o,
  input  logic                 err_ready_i,
  output logic [ID_W-1:0]      err_id_o
);

  typedef enum logic [1:0] {IDLE, SNOOP, FWD, ERR} state_t;

  state_t             state_reg, state_next;
  aw_chan_t           aw_reg;
  logic [3:0]         snoop_reg;
  logic [IDX_W-1:0]   init_reg;
  logic [NUM_SNP-1:0] ac_pend_reg, ac_pend_next;
  logic [NUM_SNP-1:0] cr_pend_reg, cr_pend_next;
  logic [4:0]         cr_resp_reg, cr_resp_next;
  logic               accept;

  logic [NUM_SNP-1:0] peer_mask;
  logic [NUM_SNP-1:0] init_mask;
  logic [NUM_SNP-1:0] ac_hs;
  logic [NUM_SNP-1:0] cr_hs;
  logic [4:0]         cr_resp_port [NUM_SNP];

  // Per-port handshakes; responses from ports that did not complete a CR are masked to zero.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SNP; gi++) begin : g_port
      assign peer_mask[gi]    = (init_idx_i != IDX_W'(gi));
      assign init_mask[gi]    = (init_reg == IDX_W'(gi));
      assign ac_hs[gi]        = ac_valid_o[gi] & ac_ready_i[gi];
      assign cr_hs[gi]        = cr_ready_o[gi] & cr_valid_i[gi];
      assign cr_resp_port[gi] = cr_hs[gi] ? cr_resp_i[5*gi +: 5] : 5'b00000;
    end
  endgenerate

  // Readies are held low while reset is asserted so nothing is accepted in that cycle.
  assign aw_ready_o  = (state_reg == IDLE) & ~rst_i;
  assign accept      = aw_valid_i & aw_ready_o;
  assign ac_valid_o  = (state_reg == SNOOP) ? (ac_pend_reg & ~init_mask) : '0;
  assign cr_ready_o  = (state_reg == SNOOP) ? cr_pend_reg : '0;
  assign aw_valid_o  = (state_reg == FWD);
  assign err_valid_o = (state_reg == ERR);

  assign ac_addr_o  = aw_reg.addr;
  assign ac_prot_o  = aw_reg.prot;
  assign ac_snoop_o = snoop_reg;
  assign aw_o       = aw_reg;
  assign cr_resp_o  = cr_resp_reg;
  assign err_id_o   = aw_reg.id;

  always_comb begin
    state_next   = state_reg;
    ac_pend_next = ac_pend_reg;
    cr_pend_next = cr_pend_reg;
    cr_resp_next = cr_resp_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          cr_resp_next = 5'b00000;
          if (illegal_trs_i) begin
            state_next = ERR;
          end else if (snooping_i && (NUM_SNP > 1)) begin
            state_next   = SNOOP;
            ac_pend_next = peer_mask;
            cr_pend_next = '0;
          end else begin
            state_next = FWD;
          end
        end
      end
      SNOOP: begin
        // An accepted AC opens a CR slot on that port; the CR cannot arrive in the same cycle.
        ac_pend_next = ac_pend_reg & ~ac_hs;
        cr_pend_next = (cr_pend_reg & ~cr_hs) | ac_hs;
        for (int k = 0; k < NUM_SNP; k++) begin
          cr_resp_next = cr_resp_next | cr_resp_port[k];
        end
        if ((ac_pend_next == '0) && (cr_pend_next == '0)) begin
          state_next = FWD;
        end
      end
      FWD: begin
        if (aw_ready_i) state_next = IDLE;
      end
      ERR: begin
        if (err_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      ac_pend_reg <= '0;
      cr_pend_reg <= '0;
      cr_resp_reg <= 5'b00000;
      aw_reg      <= '0;
      snoop_reg   <= 4'b0000;
      init_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      ac_pend_reg <= ac_pend_next;
      cr_pend_reg <= cr_pend_next;
      cr_resp_reg <= cr_resp_next;
      if (accept) begin
        aw_reg    <= aw_i;
        snoop_reg <= snoop_info_i.snoop_trs;
        init_reg  <= init_idx_i;
      end
    end
  end

endmodule

// File: tb/tb_ace_aw_snoop_dispatcher.sv
// Directed bench for ace_aw_snoop_dispatcher with four snoop ports; forwarded AWs and error
// reports are checked against scoreboard queues filled when each write is issued.
module tb_ace_aw_snoop_dispatcher;
  import ace_aw_snoop_pkg::*;

  localparam int NUM_SNP = 4;
  localparam int IDX_W   = 2;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [2:0]  prot;
    logic [4:0]  resp;
  } exp_t;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               aw_valid_i;
  logic               aw_ready_o;
  aw_chan_t           aw_i;
  logic [IDX_W-1:0]   init_idx_i;
  logic               snooping_i;
  snoop_info_t        snoop_info_i;
  logic               illegal_trs_i;
  logic [NUM_SNP-1:0] ac_valid_o;
  logic [NUM_SNP-1:0] ac_ready_i;
  logic [31:0]        ac_addr_o;
  logic [2:0]         ac_prot_o;
  logic [3:0]         ac_snoop_o;
  logic [NUM_SNP-1:0] cr_valid_i;
  logic [NUM_SNP-1:0] cr_ready_o;
  logic [5*NUM_SNP-1:0] cr_resp_i;
  logic               aw_valid_o;
  logic               aw_ready_i;
  aw_chan_t           aw_o;
  logic [4:0]         cr_resp_o;
  logic               err_valid_o;
  logic               err_ready_i;
  logic [3:0]         err_id_o;

  int checks = 0;
  int errors = 0;
  exp_t       exp_aw_q[$];
  logic [3:0] exp_err_q[$];

  always #5 clk_i = ~clk_i;

  ace_aw_snoop_dispatcher #(.NUM_SNP(NUM_SNP)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_i(aw_i),
    .init_idx_i(init_idx_i), .snooping_i(snooping_i), .snoop_info_i(snoop_info_i),
    .illegal_trs_i(illegal_trs_i),
    .ac_valid_o(ac_valid_o), .ac_ready_i(ac_ready_i), .ac_addr_o(ac_addr_o),
    .ac_prot_o(ac_prot_o), .ac_snoop_o(ac_snoop_o),
    .cr_valid_i(cr_valid_i), .cr_ready_o(cr_ready_o), .cr_resp_i(cr_resp_i),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_o(aw_o), .cr_resp_o(cr_resp_o),
    .err_valid_o(err_valid_o), .err_ready_i(err_ready_i), .err_id_o(err_id_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present one AW until accepted, then scramble the decoder inputs so later sampling would show.
  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [2:0] prot,
                         input logic [3:0] snp, input logic snooping, input logic illegal,
                         input logic [1:0] init);
    int n = 0;
    aw_valid_i = 1'b1;
    aw_i.id = id; aw_i.addr = addr; aw_i.prot = prot;
    snoop_info_i.snoop_trs = snp;
    snooping_i = snooping; illegal_trs_i = illegal; init_idx_i = init;
    while (!aw_ready_o && n < 50) begin step(); n++; end
    check("aw_accept_wait", aw_ready_o, 1'b1);
    step();
    $display("issued AW id=%0h addr=%0h snoop=%0h snooping=%0b illegal=%0b init=%0d",
             id, addr, snp, snooping, illegal, init);
    aw_valid_i = 1'b0;
    aw_i = '1;
    snoop_info_i.snoop_trs = ~snp;
    snooping_i = ~snooping; illegal_trs_i = 1'b1; init_idx_i = init + 2'd1;
  endtask

  task automatic expect_fwd();
    int n = 0;
    exp_t e;
    aw_ready_i = 1'b1;
    while (!aw_valid_o && n < 50) begin step(); n++; end
    check("fwd_seen", aw_valid_o, 1'b1);
    if (aw_valid_o) begin
      check("sb_nonempty", exp_aw_q.size() != 0, 1'b1);
      if (exp_aw_q.size() != 0) begin
        e = exp_aw_q.pop_front();
        check("fwd_id", aw_o.id, e.id);
        check("fwd_addr", aw_o.addr, e.addr);
        check("fwd_prot", aw_o.prot, e.prot);
        check("fwd_resp", cr_resp_o, e.resp);
        $display("forwarded AW id=%0h addr=%0h prot=%0h resp=%0h", aw_o.id, aw_o.addr, aw_o.prot, cr_resp_o);
      end
      step();
      check("b2b_ready", aw_ready_o, 1'b1);
    end
  endtask

  initial begin
    rst_i = 1'b1; aw_valid_i = 1'b0; aw_i = '0; init_idx_i = '0; snooping_i = 1'b0;
    snoop_info_i = '0; illegal_trs_i = 1'b0; ac_ready_i = '0; cr_valid_i = '0;
    cr_resp_i = '0; aw_ready_i = 1'b0; err_ready_i = 1'b0;
    step(); step();
    check("rst_aw_ready", aw_ready_o, 1'b0);
    check("rst_ac_valid", ac_valid_o, 4'b0000);
    check("rst_cr_ready", cr_ready_o, 4'b0000);
    check("rst_aw_valid", aw_valid_o, 1'b0);
    check("rst_err_valid", err_valid_o, 1'b0);
    check("rst_cr_resp", cr_resp_o, 5'b00000);
    rst_i = 1'b0;
    #1;
    check("post_rst_aw_ready", aw_ready_o, 1'b1);

    // WriteUnique from port 1: all three peers snooped with CleanInvalid, minimum latency.
    ac_ready_i = '1; aw_ready_i = 1'b1;
    exp_aw_q.push_back('{4'h2, 32'h1000_0040, 3'b010, 5'b00100});
    send_aw(4'h2, 32'h1000_0040, 3'b010, ACSNOOP_CLEAN_INVALID, 1'b1, 1'b0, 2'd1);
    check("wu_ac_valid", ac_valid_o, 4'b1101);
    check("wu_ac_snoop", ac_snoop_o, ACSNOOP_CLEAN_INVALID);
    check("wu_ac_addr", ac_addr_o, 32'h1000_0040);
    check("wu_ac_prot", ac_prot_o, 3'b010);
    check("wu_cr_ready_n1", cr_ready_o, 4'b0000);
    step();
    check("wu_ac_done", ac_valid_o, 4'b0000);
    check("wu_cr_ready", cr_ready_o, 4'b1101);
    check("wu_no_fwd_n2", aw_valid_o, 1'b0);
    cr_valid_i = 4'b1101;
    cr_resp_i = {5'b00100, 5'b00000, 5'b00000, 5'b00000};
    step();
    cr_valid_i = '0;
    check("wu_fwd_n3", aw_valid_o, 1'b1);
    expect_fwd();

    // Non-snooping write accepted back-to-back; response must clear to zero.
    exp_aw_q.push_back('{4'h3, 32'h2000_0100, 3'b000, 5'b00000});
    send_aw(4'h3, 32'h2000_0100, 3'b000, 4'b0000, 1'b0, 1'b0, 2'd0);
    check("ns_fwd_n1", aw_valid_o, 1'b1);
    check("ns_no_ac", ac_valid_o, 4'b0000);
    expect_fwd();

    // WriteLineUnique from port 3: staggered AC readies, CRs out of order, port 3 keeps a stray CR up.
    ac_ready_i = 4'b0001;
    cr_valid_i = 4'b1000;
    cr_resp_i = {5'b10000, 5'b00000, 5'b00000, 5'b00000};
    exp_aw_q.push_back('{4'h9, 32'h3000_0080, 3'b001, 5'b00011});
    send_aw(4'h9, 32'h3000_0080, 3'b001, ACSNOOP_MAKE_INVALID, 1'b1, 1'b0, 2'd3);
    check("wlu_ac_valid_n1", ac_valid_o, 4'b0111);
    check("wlu_ac_snoop", ac_snoop_o, ACSNOOP_MAKE_INVALID);
    check("wlu_cr_ready_n1", cr_ready_o, 4'b0000);
    step();
    check("wlu_ac_valid_n2", ac_valid_o, 4'b0110);
    check("wlu_cr_ready_n2", cr_ready_o, 4'b0001);
    ac_ready_i = 4'b0010;
    step();
    check("wlu_ac_valid_n3", ac_valid_o, 4'b0100);
    check("wlu_cr_ready_n3", cr_ready_o, 4'b0011);
    ac_ready_i = 4'b0000;
    step();
    check("wlu_ac_valid_n4", ac_valid_o, 4'b0100);
    ac_ready_i = 4'b0100;
    step();
    check("wlu_ac_valid_n5", ac_valid_o, 4'b0000);
    check("wlu_cr_ready_n5", cr_ready_o, 4'b0111);
    cr_valid_i = 4'b1100;
    cr_resp_i = {5'b10000, 5'b00010, 5'b00000, 5'b00000};
    step();
    check("wlu_cr_ready_n6", cr_ready_o, 4'b0011);
    check("wlu_no_fwd_n6", aw_valid_o, 1'b0);
    cr_valid_i = 4'b1111;
    cr_resp_i = {5'b10000, 5'b01000, 5'b00000, 5'b00001};
    step();
    cr_valid_i = '0;
    check("wlu_fwd_n7", aw_valid_o, 1'b1);
    check("wlu_cr_ready_n7", cr_ready_o, 4'b0000);
    expect_fwd();

    // Illegal write: error report held under err_ready backpressure, nothing snooped or forwarded.
    ac_ready_i = '1; err_ready_i = 1'b0;
    exp_err_q.push_back(4'h7);
    send_aw(4'h7, 32'h4000_0000, 3'b000, ACSNOOP_CLEAN_INVALID, 1'b1, 1'b1, 2'd0);
    for (int i = 0; i < 5; i++) begin
      check("err_valid_held", err_valid_o, 1'b1);
      check("err_id_held", err_id_o, 4'h7);
      check("err_no_ac", ac_valid_o, 4'b0000);
      check("err_no_fwd", aw_valid_o, 1'b0);
      check("err_aw_ready", aw_ready_o, 1'b0);
      step();
    end
    check("err_valid_hs", err_valid_o, 1'b1);
    if (exp_err_q.size() != 0) check("err_id_hs", err_id_o, exp_err_q.pop_front());
    $display("error report id=%0h", err_id_o);
    err_ready_i = 1'b1;
    step();
    err_ready_i = 1'b0;
    check("err_done", err_valid_o, 1'b0);
    check("err_idle_ready", aw_ready_o, 1'b1);

    // Downstream backpressure with stray CRs on every port.
    aw_ready_i = 1'b0;
    exp_aw_q.push_back('{4'h5, 32'h5555_0004, 3'b111, 5'b00000});
    send_aw(4'h5, 32'h5555_0004, 3'b111, 4'b0000, 1'b0, 1'b0, 2'd2);
    cr_valid_i = '1; cr_resp_i = '1;
    for (int i = 0; i < 10; i++) begin
      check("bp_aw_valid", aw_valid_o, 1'b1);
      check("bp_aw_id", aw_o.id, 4'h5);
      check("bp_aw_addr", aw_o.addr, 32'h5555_0004);
      check("bp_aw_ready", aw_ready_o, 1'b0);
      check("bp_cr_ready", cr_ready_o, 4'b0000);
      step();
    end
    cr_valid_i = '0; cr_resp_i = '0;
    expect_fwd();

    // Reset while two CRs are outstanding: the partial write is dropped.
    ac_ready_i = 4'b0110;
    send_aw(4'hA, 32'h6000_0000, 3'b000, ACSNOOP_CLEAN_INVALID, 1'b1, 1'b0, 2'd0);
    check("mid_ac_valid_n1", ac_valid_o, 4'b1110);
    step();
    check("mid_cr_ready_n2", cr_ready_o, 4'b0110);
    rst_i = 1'b1;
    step();
    check("mid_rst_ac_valid", ac_valid_o, 4'b0000);
    check("mid_rst_cr_ready", cr_ready_o, 4'b0000);
    check("mid_rst_aw_valid", aw_valid_o, 1'b0);
    check("mid_rst_aw_ready", aw_ready_o, 1'b0);
    check("mid_rst_cr_resp", cr_resp_o, 5'b00000);
    rst_i = 1'b0;
    #1;
    check("mid_post_aw_ready", aw_ready_o, 1'b1);
    check("mid_post_ac_valid", ac_valid_o, 4'b0000);
    check("mid_post_cr_ready", cr_ready_o, 4'b0000);
    check("mid_post_err_valid", err_valid_o, 1'b0);

    ac_ready_i = '1;
    exp_aw_q.push_back('{4'hB, 32'h7000_0010, 3'b100, 5'b01001});
    send_aw(4'hB, 32'h7000_0010, 3'b100, ACSNOOP_CLEAN_INVALID, 1'b1, 1'b0, 2'd2);
    check("post_ac_valid_n1", ac_valid_o, 4'b1011);
    step();
    check("post_cr_ready_n2", cr_ready_o, 4'b1011);
    cr_valid_i = 4'b1011;
    cr_resp_i = {5'b01000, 5'b11111, 5'b00001, 5'b00000};
    step();
    cr_valid_i = '0;
    expect_fwd();

    for (int i = 0; i < 3; i++) begin
      check("drain_no_fwd", aw_valid_o, 1'b0);
      step();
    end
    check("sb_aw_empty", exp_aw_q.size(), 0);
    check("sb_err_empty", exp_err_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
